// File: rtl/axis_packet_streamer.sv
// Packet buffer read controller: owns slot pointers/occupancy and serializes each packet into AXI-Stream beats.
// Latency: commit into empty buffer -> first tvalid 2+READ_LATENCY cycles later; back-to-back gap of 1+READ_LATENCY.
// Backpressure: beats hold on tready=0; upstream held off by buf_full. Optional FPGA_AXIS_SEQ_HEADER_EN prepends a sequence header beat.
module axis_packet_streamer #(
    parameter int DATA_WIDTH             = 16000,
    parameter int NUM_PACKETS_PER_BUFFER = 8,
    parameter int AXIS_DATA_WIDTH        = 512,
    parameter int READ_LATENCY           = 1,
    localparam int AW = $clog2(NUM_PACKETS_PER_BUFFER),
    localparam int KW = AXIS_DATA_WIDTH / 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pkt_commit,
    output logic [AW-1:0]              buf_wr_addr,
    output logic                       buf_full,
    output logic [AW-1:0]              buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]      buf_rd_data,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KW-1:0]              m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       overflow
);

    localparam int BEATS = (DATA_WIDTH + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
`ifdef FPGA_AXIS_SEQ_HEADER_EN
    localparam int TOTAL = BEATS + 1;
`else
    localparam int TOTAL = BEATS;
`endif
    localparam int BW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    localparam logic [AW:0]   NUM_C     = (AW+1)'(NUM_PACKETS_PER_BUFFER);
    localparam logic [BW-1:0] LAST_BEAT = BW'(TOTAL - 1);
    localparam logic [LW-1:0] LAT_DONE  = LW'(READ_LATENCY - 1);

    logic [1:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [BW-1:0] beat;
    logic [LW-1:0] lat;
    logic          overflow_q;
    logic          handshake;
    logic          last_hs;
    logic          full;
    logic          commit_ok;

    logic [BEATS*AXIS_DATA_WIDTH-1:0] padded;
    logic [BW-1:0]                    data_idx;
    logic [AXIS_DATA_WIDTH-1:0]       beat_data;

    assign full      = (count == NUM_C);
    assign handshake = (state == S_STREAM) && m_axis_tready;
    assign last_hs   = handshake && (beat == LAST_BEAT);
    // A release in the same cycle frees a slot, so a commit at full is still taken then.
    assign commit_ok = pkt_commit && (!full || last_hs);

    // Occupancy after this cycle's commit and release.
    always_comb begin
        count_next = count;
        unique case ({commit_ok, last_hs})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // Slot pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (commit_ok) wr_ptr <= wr_ptr + AW'(1);
            if (last_hs)   rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            if (pkt_commit && !commit_ok) overflow_q <= 1'b1;
        end
    end

    // Read sequencer: wait out buffer latency, then walk the beats of one packet.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            beat  <= '0;
            lat   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state <= S_FETCH;
                        lat   <= '0;
                    end
                end
                S_FETCH: begin
                    if (lat == LAT_DONE) begin
                        state <= S_STREAM;
                        beat  <= '0;
                    end else begin
                        lat <= lat + LW'(1);
                    end
                end
                S_STREAM: begin
                    if (handshake) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            lat   <= '0;
                            state <= (count_next != '0) ? S_FETCH : S_IDLE;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FPGA_AXIS_SEQ_HEADER_EN
    logic [31:0] seq;

    // Packet sequence number, advanced once per completed packet.
    always_ff @(posedge clock) begin
        if (reset) begin
            seq <= '0;
        end else if (last_hs) begin
            seq <= seq + 32'd1;
        end
    end

    // Beat 0 is the header; data beats follow shifted by one.
    always_comb begin
        padded                   = '0;
        padded[DATA_WIDTH-1:0]   = buf_rd_data;
        data_idx                 = beat - BW'(1);
        beat_data                = '0;
        if (beat == '0) begin
            beat_data[31:0]  = seq;
            beat_data[47:32] = 16'(BEATS);
        end else begin
            beat_data = padded[int'(data_idx)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        end
    end
`else
    // Select the current beat slice, zero-padding above the packet width.
    always_comb begin
        padded                 = '0;
        padded[DATA_WIDTH-1:0] = buf_rd_data;
        data_idx               = beat;
        beat_data              = padded[int'(data_idx)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    end
`endif

    assign m_axis_tvalid = (state == S_STREAM);
    assign m_axis_tdata  = m_axis_tvalid ? beat_data : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? '1 : '0;
    assign m_axis_tlast  = m_axis_tvalid && (beat == LAST_BEAT);
    assign buf_wr_addr   = wr_ptr;
    assign buf_rd_addr   = rd_ptr;
    assign buf_full      = full;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_packet_streamer.sv
// Bench for axis_packet_streamer: buffer model plus scoreboard of expected beats.
// Stimulus pushes expected beats on each accepted commit; a negedge monitor pops on handshake.
// Directed scenarios: latency, fill/overflow, stalls, commit+release, wrap, mid-packet reset.
module tb_axis_packet_streamer;

    localparam int DW    = 16000;
    localparam int NUM   = 8;
    localparam int AXW   = 512;
    localparam int AW    = 3;
    localparam int BEATS = 32;
    localparam int WORDS = DW / 32;

    typedef struct packed {
        logic [AXW-1:0] d;
        logic           l;
    } beat_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              pkt_commit = 1'b0;
    logic [AW-1:0]     buf_wr_addr;
    logic              buf_full;
    logic [AW-1:0]     buf_rd_addr;
    logic [DW-1:0]     buf_rd_data;
    logic [AXW-1:0]    m_axis_tdata;
    logic [AXW/8-1:0]  m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tlast;
    logic              overflow;

    logic              commit_ok = 1'b0;
    logic [DW-1:0]     wdata = '0;
    logic [DW-1:0]     mem [NUM];

    beat_t             sb[$];
    int                checks = 0;
    int                errors = 0;
    logic [31:0]       seq_model = 0;

    axis_packet_streamer dut (
        .clock(clock), .reset(reset), .pkt_commit(pkt_commit),
        .buf_wr_addr(buf_wr_addr), .buf_full(buf_full), .buf_rd_addr(buf_rd_addr),
        .buf_rd_data(buf_rd_data), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Buffer RAM with one cycle read latency; the packer writes only accepted commits.
    always @(posedge clock) begin
        if (pkt_commit && commit_ok) mem[buf_wr_addr] <= wdata;
        buf_rd_data <= mem[buf_rd_addr];
    end

    function automatic logic [31:0] pat(input logic [31:0] id, input logic [31:0] j);
        return {id[7:0], 8'hA5, j[15:0]};
    endfunction

    function automatic logic [DW-1:0] make_pkt(input int id);
        logic [DW-1:0] p;
        p = '0;
        for (int j = 0; j < WORDS; j++) p[j*32 +: 32] = pat(id, j);
        return p;
    endfunction

    function automatic logic [AXW-1:0] exp_beat(input int id, input int k);
        logic [AXW-1:0] b;
        b = '0;
        for (int c = 0; c < AXW/32; c++) begin
            if (k*16 + c < WORDS) b[c*32 +: 32] = pat(id, k*16 + c);
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [AXW-1:0] act, input logic [AXW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_packet(input int id);
        beat_t e;
`ifdef FPGA_AXIS_SEQ_HEADER_EN
        e.d = '0;
        e.d[31:0]  = seq_model;
        e.d[47:32] = 16'(BEATS);
        e.l = 1'b0;
        sb.push_back(e);
        seq_model = seq_model + 1;
`endif
        for (int k = 0; k < BEATS; k++) begin
            e.d = exp_beat(id, k);
            e.l = (k == BEATS - 1);
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with commit deasserted.
    task automatic commit(input int id, input logic ok);
        pkt_commit = 1'b1;
        commit_ok  = ok;
        wdata      = make_pkt(id);
        if (ok) push_packet(id);
        @(posedge clock); #1;
        pkt_commit = 1'b0;
        commit_ok  = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input logic random_ready);
        int n;
        n = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && n < budget) begin
            m_axis_tready = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clock); #1;
            n++;
        end
        check("drain_timeout", AXW'(n < budget), AXW'(1));
    endtask

    // Monitor: pops expected beats on handshake, checks idle zeros, stall hold and inter-packet gap.
    logic           stall_prev = 1'b0;
    logic [AXW-1:0] stall_d;
    logic           stall_l;
    logic           gap_armed = 1'b0;
    int             gap_cnt = 0;
    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_prev = 1'b0;
                gap_armed  = 1'b0;
            end else begin
                if (gap_armed) begin
                    gap_cnt++;
                    if (m_axis_tvalid || gap_cnt >= 3) begin
                        check("gap_cycles", AXW'(gap_cnt), AXW'(2));
                        gap_armed = 1'b0;
                    end
                end
                if (stall_prev) begin
                    check("stall_valid", AXW'(m_axis_tvalid), AXW'(1));
                    check("stall_data", m_axis_tdata, stall_d);
                    check("stall_last", AXW'(m_axis_tlast), AXW'(stall_l));
                end
                if (!m_axis_tvalid) begin
                    check("idle_zero", {m_axis_tdata[AXW-1:2], m_axis_tlast, |m_axis_tkeep}, '0);
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                stall_d    = m_axis_tdata;
                stall_l    = m_axis_tlast;
                if (m_axis_tvalid && m_axis_tready) begin
                    check("keep", AXW'(m_axis_tkeep), AXW'({(AXW/8){1'b1}}));
                    if (sb.size() == 0) begin
                        check("unexpected_beat", AXW'(1), AXW'(0));
                    end else begin
                        e = sb.pop_front();
                        check("beat_data", m_axis_tdata, e.d);
                        check("beat_last", AXW'(m_axis_tlast), AXW'(e.l));
                        if (m_axis_tlast && sb.size() != 0) begin
                            gap_armed = 1'b1;
                            gap_cnt   = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int  n;
        logic found;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tvalid", AXW'(m_axis_tvalid), '0);
        check("rst_addr", AXW'({buf_wr_addr, buf_rd_addr, buf_full, overflow}), '0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 1: single packet latency and full stream.
        m_axis_tready = 1'b1;
        commit(1, 1'b1);
        check("t1_wr_addr", AXW'(buf_wr_addr), AXW'(1));
        check("t1_c1_valid", AXW'(m_axis_tvalid), AXW'(0));
        @(posedge clock); #1;
        check("t1_c2_valid", AXW'(m_axis_tvalid), AXW'(0));
        @(posedge clock); #1;
        check("t1_c3_valid", AXW'(m_axis_tvalid), AXW'(1));
        wait_drain(200, 1'b0);
        check("t1_empty", AXW'({buf_rd_addr, buf_full}), AXW'({3'd1, 1'b0}));

        // 2: fill all slots with tready low, then overflow.
        m_axis_tready = 1'b0;
        for (int i = 2; i <= 9; i++) commit(i, 1'b1);
        check("t2_full", AXW'(buf_full), AXW'(1));
        check("t2_wr_addr", AXW'(buf_wr_addr), AXW'(1));
        check("t2_no_ovf", AXW'(overflow), AXW'(0));
        commit(99, 1'b0);
        check("t2_ovf", AXW'(overflow), AXW'(1));
        check("t2_wr_hold", AXW'({buf_wr_addr, buf_full}), AXW'({3'd1, 1'b1}));

        // 3+4: random stalls until first packet's last beat, then commit on its release.
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_axis_tvalid && m_axis_tlast) begin
                found = 1'b1;
                break;
            end
            m_axis_tready = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        check("t3_reach_last", AXW'(found), AXW'(1));
        m_axis_tready = 1'b1;
        commit(10, 1'b1);
        check("t4_full", AXW'(buf_full), AXW'(1));
        check("t4_ptrs", AXW'({buf_wr_addr, buf_rd_addr}), AXW'({3'd2, 3'd2}));
        check("t4_fetch", AXW'(m_axis_tvalid), AXW'(0));

        // 5: more commits as space frees, wrapping the slot pointers.
        for (int id = 11; id <= 13; id++) begin
            n = 0;
            while (buf_full && n < 2000) begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
                @(posedge clock); #1;
                n++;
            end
            check("t5_space", AXW'(buf_full), AXW'(0));
            commit(id, 1'b1);
        end
        wait_drain(5000, 1'b1);
        check("t5_ptrs", AXW'({buf_wr_addr, buf_rd_addr, buf_full}), AXW'({3'd5, 3'd5, 1'b0}));

        // 6: reset while beat 10 is presented.
        m_axis_tready = 1'b1;
        commit(14, 1'b1);
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("t6_start", AXW'(m_axis_tvalid), AXW'(1));
        repeat (10) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        sb.delete();
        seq_model = 0;
        @(posedge clock); #1;
        check("t6_tvalid", AXW'(m_axis_tvalid), AXW'(0));
        check("t6_state", AXW'({buf_wr_addr, buf_rd_addr, buf_full, overflow}), '0);
        reset = 1'b0;
        @(posedge clock); #1;
        commit(20, 1'b1);
        check("t6_wr_addr", AXW'(buf_wr_addr), AXW'(1));
        wait_drain(200, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
